// File: rtl/axi_read_arbiter.sv
// Two-port AXI read arbiter: fetch (port 0) and load (port 1) share one AR/R path, one burst in flight.
// Define ARB_FETCH_PRIORITY_EN for fixed fetch priority; otherwise round-robin.
module axi_read_arbiter #(
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [7:0]            req_len0,
  input  logic [7:0]            req_len1,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic                    gnt_q;
  logic                    win;
  logic                    load;
  logic                    done;
  logic                    rready_c;

  // Beats are routed by grant alone, so rid and the low rresp bit are never looked at.
  logic                    unused_inputs;
  assign unused_inputs = ^{m_axi_rid, m_axi_rresp[0]};

`ifdef ARB_FETCH_PRIORITY_EN
  assign win = ~req_valid[0];
`else
  logic last_q;
  assign win = (&req_valid) ? ~last_q : req_valid[1];

  // Round-robin pointer: port that finished the most recent burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (done) begin
      last_q <= gnt_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request held on the AR channel until the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      len_q  <= '0;
      gnt_q  <= 1'b0;
    end else if (load) begin
      addr_q <= win ? req_addr1 : req_addr0;
      len_q  <= win ? req_len1 : req_len0;
      gnt_q  <= win;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 2'b00;
    load          = 1'b0;
    done          = 1'b0;
    m_axi_arvalid = 1'b0;
    rready_c      = 1'b0;
    resp_valid    = 2'b00;
    resp_data     = '0;
    resp_last     = 1'b0;
    resp_err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gate with reset so nothing is offered while reset is held.
        if (reset && (|req_valid)) begin
          req_ready = win ? 2'b10 : 2'b01;
          load      = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        rready_c   = resp_ready[gnt_q];
        resp_valid = gnt_q ? {m_axi_rvalid, 1'b0} : {1'b0, m_axi_rvalid};
        resp_data  = m_axi_rdata;
        resp_last  = m_axi_rlast;
        resp_err   = m_axi_rresp[1];
        if (m_axi_rvalid && rready_c && m_axi_rlast) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign m_axi_rready  = rready_c;
  assign m_axi_arid    = ID_WIDTH'(gnt_q);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'd3;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

endmodule
